// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: FSM states, widths and the MEM/WB bundle.
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // MEM/WB bundle as seen by the register file and the forwarding unit
  localparam int WB_W = 1 + REG_ADDR_W + DATA_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0]     write_data;
  } memwb_t;

  // Word accesses must have the two low address bits clear
  function automatic logic misaligned(input logic [1:0] lo);
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_sync.sv
// Synchronous data RAM: one write port, one registered read port.
module dmem_sync
  import pipe_pkg::*;
#(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [WORDS];

  // Write and registered read; read data holds when no read is issued
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage with data memory, MEM/WB register and load-latency FSM.
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int DMEM_WORDS = 256,
  parameter int MEM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ex_valid,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_mem_to_reg,
  input  logic [REG_ADDR_W-1:0] ex_write_reg,
  input  logic [DATA_W-1:0]     ex_alu_result,
  input  logic [DATA_W-1:0]     ex_store_data,
  input  logic                  flush,
  output logic                  stall_out,
  output logic                  reg_write,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0]     write_data,
  output logic                  misalign_err
);

  localparam int AW = $clog2(DMEM_WORDS);
  localparam int CW = 3;

  state_t                state, state_nx;
  logic [CW-1:0]         cnt, cnt_nx;

  logic                  accept;
  logic                  mis;
  logic                  ld_acc;
  logic                  st_we;
  logic                  qual_now;
  logic                  final_ld;
  logic [AW-1:0]         idx;

  // Pending load captured at accept while the FSM waits out the latency
  logic [AW-1:0]         pend_idx;
  logic [REG_ADDR_W-1:0] pend_wreg;
  logic                  pend_qual;
  logic                  pend_m2r;
  logic [DATA_W-1:0]     pend_alu;

  // MEM/WB register: write_data is either the ALU value or the RAM read port
  logic [DATA_W-1:0]     wb_alu_p1;
  logic                  wb_sel_mem_p1;

  logic                  ram_re;
  logic [AW-1:0]         ram_raddr;
  logic [DATA_W-1:0]     ram_q;

  assign idx      = ex_alu_result[AW+1:2];
  assign accept   = (state == ST_IDLE) && ex_valid && !flush && !reset;
  assign mis      = (ex_mem_read || ex_mem_write) && misaligned(ex_alu_result[1:0]);
  assign ld_acc   = accept && ex_mem_read;
  assign st_we    = accept && ex_mem_write && !ex_mem_read && !mis;
  assign qual_now = ex_reg_write && (ex_write_reg != '0) && !mis;
  assign final_ld = (state == ST_WAIT) && !flush && (cnt == CW'(1));

  assign stall_out = (state == ST_WAIT);

  // The RAM is read at the edge the write-back is produced
  assign ram_re    = (ld_acc && (MEM_LAT == 1)) || final_ld;
  assign ram_raddr = (state == ST_WAIT) ? pend_idx : idx;

  dmem_sync #(
    .WORDS (DMEM_WORDS),
    .AW    (AW)
  ) u_dmem (
    .clk   (clk),
    .we    (st_we),
    .waddr (idx),
    .wdata (ex_store_data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  // Next-state logic: multi-cycle loads park in WAIT until the count expires
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        if (ld_acc && (MEM_LAT > 1)) begin
          state_nx = ST_WAIT;
          cnt_nx   = CW'(MEM_LAT - 1);
        end
      end
      ST_WAIT: begin
        if (flush || (cnt == CW'(1))) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx   = cnt - CW'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // FSM state and latency counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Capture the load being waited on
  always_ff @(posedge clk) begin
    if (ld_acc) begin
      pend_idx  <= idx;
      pend_wreg <= ex_write_reg;
      pend_qual <= qual_now;
      pend_m2r  <= ex_mem_to_reg;
      pend_alu  <= ex_alu_result;
    end
  end

  // MEM/WB register and sticky misalignment flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write     <= 1'b0;
      write_reg     <= '0;
      wb_alu_p1     <= '0;
      wb_sel_mem_p1 <= 1'b0;
      misalign_err  <= 1'b0;
    end else begin
      reg_write <= 1'b0;
      if (accept && mis) misalign_err <= 1'b1;
      if (final_ld) begin
        reg_write     <= pend_qual;
        write_reg     <= pend_wreg;
        wb_alu_p1     <= pend_alu;
        wb_sel_mem_p1 <= pend_m2r;
      end else if (accept) begin
        if (!ex_mem_read) begin
          reg_write     <= ex_reg_write && (ex_write_reg != '0) && !ex_mem_write;
          write_reg     <= ex_write_reg;
          wb_alu_p1     <= ex_alu_result;
          wb_sel_mem_p1 <= 1'b0;
        end else if (MEM_LAT == 1) begin
          reg_write     <= qual_now;
          write_reg     <= ex_write_reg;
          wb_alu_p1     <= ex_alu_result;
          wb_sel_mem_p1 <= ex_mem_to_reg;
        end
      end
    end
  end

  assign write_data = wb_sel_mem_p1 ? ram_q : wb_alu_p1;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench: MEM_LAT=1 and MEM_LAT=3 instances share one stimulus stream.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0, ex_reg_write = 1'b0, ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0, ex_mem_to_reg = 1'b0, flush = 1'b0;
  logic [4:0]  ex_write_reg = '0;
  logic [31:0] ex_alu_result = '0, ex_store_data = '0;

  logic [1:0]  rw, stall, mis;
  logic [4:0]  wreg  [2];
  logic [31:0] wdata [2];

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;

  // Reference model state, per instance (0: latency 1, 1: latency 3)
  logic [31:0] mmem [2][256];
  bit          pend  [2];
  int          due   [2];
  logic [4:0]  p_wr  [2];
  logic [7:0]  p_idx [2];
  bit          p_q   [2];
  bit          p_m2r [2];
  logic [31:0] p_alu [2];
  bit          exp_rw [2];
  bit          exp_stall [2];
  bit          exp_mis [2];
  logic [4:0]  exp_wreg [2];
  logic [31:0] exp_wdata [2];

  always #5 clk = ~clk;

  mem_wb_stage #(.DMEM_WORDS(256), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_write_reg(ex_write_reg), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .flush(flush), .stall_out(stall[0]), .reg_write(rw[0]), .write_reg(wreg[0]),
    .write_data(wdata[0]), .misalign_err(mis[0]));

  mem_wb_stage #(.DMEM_WORDS(256), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_write_reg(ex_write_reg), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .flush(flush), .stall_out(stall[1]), .reg_write(rw[1]), .write_reg(wreg[1]),
    .write_data(wdata[1]), .misalign_err(mis[1]));

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; exp_rw[i] = 0; exp_stall[i] = 0; exp_mis[i] = 0;
    end
  endtask

  // One clock edge of the transaction-level model: a load accepted at edge k
  // writes back at edge k+L-1 unless flushed; the instance is busy until then.
  task automatic model_step(input int i);
    int         lat;
    bit         ma, q;
    logic [7:0] idx;
    lat = (i == 0) ? 1 : 3;
    exp_rw[i] = 0;
    if (pend[i]) begin
      if (flush) pend[i] = 0;
      else if (cyc == due[i]) begin
        exp_rw[i] = p_q[i]; exp_wreg[i] = p_wr[i];
        exp_wdata[i] = p_m2r[i] ? mmem[i][p_idx[i]] : p_alu[i];
        pend[i] = 0;
      end
    end else if (ex_valid && !flush) begin
      ma  = (ex_mem_read || ex_mem_write) && (ex_alu_result % 4 != 0);
      idx = ex_alu_result[9:2];
      if (ma) exp_mis[i] = 1;
      if (ex_mem_read) begin
        q = ex_reg_write && ex_write_reg != 0 && !ma;
        if (lat == 1) begin
          exp_rw[i] = q; exp_wreg[i] = ex_write_reg;
          exp_wdata[i] = ex_mem_to_reg ? mmem[i][idx] : ex_alu_result;
        end else begin
          pend[i] = 1; due[i] = cyc + lat - 1; p_wr[i] = ex_write_reg; p_idx[i] = idx;
          p_q[i] = q; p_m2r[i] = ex_mem_to_reg; p_alu[i] = ex_alu_result;
        end
      end else begin
        exp_rw[i] = ex_reg_write && ex_write_reg != 0 && !ex_mem_write;
        exp_wreg[i] = ex_write_reg; exp_wdata[i] = ex_alu_result;
        if (ex_mem_write && !ma) mmem[i][idx] = ex_store_data;
      end
    end
    exp_stall[i] = pend[i];
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (!reset) begin
      model_step(0);
      model_step(1);
    end
    #1;
  endtask

  task automatic set_nop();
    ex_valid = 0; ex_reg_write = 0; ex_mem_read = 0; ex_mem_write = 0;
    ex_mem_to_reg = 0; flush = 0;
  endtask

  task automatic set_alu(input logic [4:0] r, input logic [31:0] v);
    set_nop(); ex_valid = 1; ex_reg_write = 1; ex_write_reg = r; ex_alu_result = v;
  endtask

  task automatic set_load(input logic [4:0] r, input logic [31:0] a);
    set_nop(); ex_valid = 1; ex_reg_write = 1; ex_mem_read = 1; ex_mem_to_reg = 1;
    ex_write_reg = r; ex_alu_result = a;
  endtask

  task automatic set_store(input logic [31:0] a, input logic [31:0] d);
    set_nop(); ex_valid = 1; ex_mem_write = 1; ex_alu_result = a; ex_store_data = d;
  endtask

  task automatic pulse_reset();
    #2 reset = 1; model_reset();
    tick();
    #2 reset = 0;
  endtask

  task automatic test_reset();
    set_nop();
    reset = 1; model_reset();
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      ntests++; if (rw[i] !== 1'b0) begin nfail++; $display("FAIL reset_rw[%0d]: got %b want 0", i, rw[i]); end
      ntests++; if (wreg[i] !== 5'd0) begin nfail++; $display("FAIL reset_wreg[%0d]: got %0d want 0", i, wreg[i]); end
      ntests++; if (wdata[i] !== 32'd0) begin nfail++; $display("FAIL reset_wdata[%0d]: got %h want 0", i, wdata[i]); end
      ntests++; if (mis[i] !== 1'b0) begin nfail++; $display("FAIL reset_mis[%0d]: got %b want 0", i, mis[i]); end
      ntests++; if (stall[i] !== 1'b0) begin nfail++; $display("FAIL reset_stall[%0d]: got %b want 0", i, stall[i]); end
    end
    #2 reset = 0;
  endtask

  task automatic test_alu();
    set_alu(5'd5, 32'h1234); tick();
    for (int i = 0; i < 2; i++) begin
      ntests++; if (rw[i] !== 1'b1) begin nfail++; $display("FAIL alu_rw[%0d]: got %b want 1", i, rw[i]); end
      ntests++; if (wreg[i] !== 5'd5) begin nfail++; $display("FAIL alu_wreg[%0d]: got %0d want 5", i, wreg[i]); end
      ntests++; if (wdata[i] !== 32'h1234) begin nfail++; $display("FAIL alu_wdata[%0d]: got %h want 1234", i, wdata[i]); end
    end
    set_nop(); tick();
    for (int i = 0; i < 2; i++) begin
      ntests++; if (rw[i] !== 1'b0) begin nfail++; $display("FAIL alu_pulse[%0d]: got %b want 0", i, rw[i]); end
    end
  endtask

  task automatic test_store_load();
    set_store(32'h10, 32'hDEADBEEF); tick();
    for (int i = 0; i < 2; i++) begin
      ntests++; if (rw[i] !== 1'b0) begin nfail++; $display("FAIL store_rw[%0d]: got %b want 0", i, rw[i]); end
    end
    set_load(5'd7, 32'h10); tick();
    ntests++; if (rw[0] !== 1'b1) begin nfail++; $display("FAIL ld1_rw: got %b want 1", rw[0]); end
    ntests++; if (wreg[0] !== 5'd7) begin nfail++; $display("FAIL ld1_wreg: got %0d want 7", wreg[0]); end
    ntests++; if (wdata[0] !== 32'hDEADBEEF) begin nfail++; $display("FAIL ld1_wdata: got %h want deadbeef", wdata[0]); end
    ntests++; if (stall[1] !== 1'b1) begin nfail++; $display("FAIL ld3_stall_a: got %b want 1", stall[1]); end
    set_nop(); tick();
    ntests++; if (rw[0] !== 1'b0) begin nfail++; $display("FAIL ld1_pulse: got %b want 0", rw[0]); end
    tick();
    ntests++; if (rw[1] !== 1'b1) begin nfail++; $display("FAIL ld3_rw: got %b want 1", rw[1]); end
    ntests++; if (wdata[1] !== 32'hDEADBEEF) begin nfail++; $display("FAIL ld3_wdata: got %h want deadbeef", wdata[1]); end
  endtask

  task automatic test_lat3_load();
    set_load(5'd9, 32'h10); tick();
    ntests++; if (stall[1] !== 1'b1 || rw[1] !== 1'b0) begin nfail++; $display("FAIL lat3_c1: stall=%b rw=%b want 1/0", stall[1], rw[1]); end
    set_alu(5'd3, 32'hABC); tick();
    ntests++; if (stall[1] !== 1'b1 || rw[1] !== 1'b0) begin nfail++; $display("FAIL lat3_c2: stall=%b rw=%b want 1/0", stall[1], rw[1]); end
    tick();
    ntests++; if (stall[1] !== 1'b0) begin nfail++; $display("FAIL lat3_stall_drop: got %b want 0", stall[1]); end
    ntests++; if (rw[1] !== 1'b1 || wreg[1] !== 5'd9) begin nfail++; $display("FAIL lat3_wb: rw=%b wreg=%0d want 1/9", rw[1], wreg[1]); end
    ntests++; if (wdata[1] !== 32'hDEADBEEF) begin nfail++; $display("FAIL lat3_wdata: got %h want deadbeef", wdata[1]); end
    tick();
    ntests++; if (rw[1] !== 1'b1 || wreg[1] !== 5'd3 || wdata[1] !== 32'hABC) begin
      nfail++; $display("FAIL lat3_held: rw=%b wreg=%0d data=%h want 1/3/abc", rw[1], wreg[1], wdata[1]); end
    set_nop(); tick();
  endtask

  task automatic test_flush_wait();
    set_load(5'd9, 32'h10); tick();
    set_nop(); tick();
    flush = 1; tick();
    ntests++; if (stall[1] !== 1'b0 || rw[1] !== 1'b0) begin nfail++; $display("FAIL flush_c: stall=%b rw=%b want 0/0", stall[1], rw[1]); end
    flush = 0; tick();
    ntests++; if (stall[1] !== 1'b0 || rw[1] !== 1'b0) begin nfail++; $display("FAIL flush_after: stall=%b rw=%b want 0/0", stall[1], rw[1]); end
    set_alu(5'd2, 32'h55); tick();
    ntests++; if (rw[1] !== 1'b1 || wreg[1] !== 5'd2) begin nfail++; $display("FAIL flush_idle: rw=%b wreg=%0d want 1/2", rw[1], wreg[1]); end
    set_nop(); tick();
  endtask

  task automatic test_zero_reg();
    set_alu(5'd0, 32'hFFFF); tick();
    for (int i = 0; i < 2; i++) begin
      ntests++; if (rw[i] !== 1'b0) begin nfail++; $display("FAIL r0_rw[%0d]: got %b want 0", i, rw[i]); end
    end
    set_nop(); tick();
  endtask

  task automatic test_misalign();
    set_store(32'h13, 32'h11111111); tick();
    for (int i = 0; i < 2; i++) begin
      ntests++; if (mis[i] !== 1'b1) begin nfail++; $display("FAIL mis_set[%0d]: got %b want 1", i, mis[i]); end
    end
    set_load(5'd4, 32'h10); tick();
    ntests++; if (rw[0] !== 1'b1 || wdata[0] !== 32'hDEADBEEF) begin nfail++; $display("FAIL mis_old1: rw=%b data=%h want 1/deadbeef", rw[0], wdata[0]); end
    set_nop(); tick(); tick();
    ntests++; if (rw[1] !== 1'b1 || wdata[1] !== 32'hDEADBEEF) begin nfail++; $display("FAIL mis_old3: rw=%b data=%h want 1/deadbeef", rw[1], wdata[1]); end
    for (int i = 0; i < 2; i++) begin
      ntests++; if (mis[i] !== 1'b1) begin nfail++; $display("FAIL mis_sticky[%0d]: got %b want 1", i, mis[i]); end
    end
    pulse_reset();
    for (int i = 0; i < 2; i++) begin
      ntests++; if (mis[i] !== 1'b0) begin nfail++; $display("FAIL mis_clear[%0d]: got %b want 0", i, mis[i]); end
    end
  endtask

  task automatic test_reset_mid_wait();
    set_load(5'd6, 32'h10); tick();
    set_nop();
    #2 reset = 1; model_reset();
    #1;
    ntests++; if (stall[1] !== 1'b0 || rw[1] !== 1'b0) begin nfail++; $display("FAIL rst_wait: stall=%b rw=%b want 0/0", stall[1], rw[1]); end
    tick();
    #2 reset = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      ntests++; if (rw[1] !== 1'b0 || stall[1] !== 1'b0) begin nfail++; $display("FAIL rst_nowb: rw=%b stall=%b want 0/0", rw[1], stall[1]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    int          op;
    for (int k = 0; k < 16; k++) begin
      set_store(($urandom() & 32'hFFFF_FC00) | 32'(k << 2), $urandom()); tick();
    end
    set_nop(); tick(); tick(); tick();
    for (int n = 0; n < 400; n++) begin
      set_nop();
      a = ($urandom() & 32'hFFFF_FC00) | 32'($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      op = $urandom_range(0, 3);
      ex_valid      = (op != 3);
      ex_reg_write  = 1'($urandom_range(0, 3) != 0);
      ex_write_reg  = 5'($urandom_range(0, 31));
      ex_store_data = $urandom();
      case (op)
        0: ex_alu_result = $urandom();
        1: begin ex_mem_read = 1; ex_mem_to_reg = 1'($urandom_range(0, 7) != 0); ex_alu_result = a; end
        2: begin ex_mem_write = 1; ex_alu_result = a; end
        default: ex_alu_result = $urandom();
      endcase
      flush = 1'($urandom_range(0, 9) == 0);
      tick();
      for (int i = 0; i < 2; i++) begin
        ntests++; if (rw[i] !== exp_rw[i]) begin nfail++; $display("FAIL rnd_rw[%0d] cyc %0d: got %b want %b", i, cyc, rw[i], exp_rw[i]); end
        ntests++; if (stall[i] !== exp_stall[i]) begin nfail++; $display("FAIL rnd_stall[%0d] cyc %0d: got %b want %b", i, cyc, stall[i], exp_stall[i]); end
        ntests++; if (mis[i] !== exp_mis[i]) begin nfail++; $display("FAIL rnd_mis[%0d] cyc %0d: got %b want %b", i, cyc, mis[i], exp_mis[i]); end
        if (exp_rw[i]) begin
          ntests++; if (wreg[i] !== exp_wreg[i] || wdata[i] !== exp_wdata[i]) begin
            nfail++; $display("FAIL rnd_wb[%0d] cyc %0d: got r%0d=%h want r%0d=%h", i, cyc, wreg[i], wdata[i], exp_wreg[i], exp_wdata[i]); end
        end
      end
    end
    set_nop(); tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store_load();
    test_lat3_load();
    test_flush_wait();
    test_zero_reg();
    test_misalign();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
